// File: rtl/epp_host.sv
// epp_host: EPP initiator that drives EppAstb/EppDstb/EppWR/EppDB.
// It paces each handshake phase on the synchronised responder EppWait.
// Build option: define EPP_HOST_TIMEOUT_EN to bound the strobe and release
// waits at TIMEOUT_CYCLES each. Without it, both waits are unbounded and
// rsp_timeout is held at 0.
`timescale 1ns/1ps
module epp_host #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       EppAstb,
  output logic       EppDstb,
  output logic       EppWR,
  input  logic       EppWait,
  inout  wire  [7:0] EppDB
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_DONE} state_t;

  localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
`ifdef EPP_HOST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       op_q, op_d;
  logic [7:0]       wdata_q, wdata_d, rdata_q, rdata_d, rsp_data_q;
  logic             astb_q, astb_d, dstb_q, dstb_d, wr_q, wr_d;
  logic             wait_m_q, wait_s_q;
  logic             abort, done_entry;

  // The wait counter saturates so a long wait in the untimed build cannot wrap.
  assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  assign done_entry = (state_d == S_DONE) && (state_q != S_DONE);

  // Two-flop synchroniser for the asynchronous responder handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_m_q <= 1'b0;
      wait_s_q <= 1'b0;
    end else begin
      wait_m_q <= EppWait;
      wait_s_q <= wait_m_q;
    end
  end

  // Next-state logic, handshake sequencing, and response bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    abort     = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          op_d    = cmd_op;
          wdata_d = cmd_data;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STROBE: begin
        cnt_d = cnt_inc;
        // A responder that is already high on entry counts as an ack.
        if (wait_s_q) begin
          if (op_q[1]) rdata_d = EppDB;
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
`ifdef EPP_HOST_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_RELEASE: begin
        cnt_d = cnt_inc;
        if (!wait_s_q) state_d = S_DONE;
`ifdef EPP_HOST_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Pins are registered from the next state so they change cleanly on the edge.
    astb_d = !((state_d == S_STROBE) && !op_d[0]);
    dstb_d = !((state_d == S_STROBE) &&  op_d[0]);
    wr_d   = !((state_d inside {S_SETUP, S_STROBE, S_RELEASE}) && !op_d[1]);
  end

  // State, command latch, and pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rsp_data_q <= '0;
      astb_q     <= 1'b1;
      dstb_q     <= 1'b1;
      wr_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      astb_q  <= astb_d;
      dstb_q  <= dstb_d;
      wr_q    <= wr_d;
      if (done_entry) rsp_data_q <= (abort || !op_q[1]) ? 8'h00 : rdata_q;
    end
  end

`ifdef EPP_HOST_TIMEOUT_EN
  logic rsp_to_q;
  // The timeout flag is captured on DONE entry and held until the next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             rsp_to_q <= 1'b0;
    else if (done_entry) rsp_to_q <= abort;
  end
  assign rsp_timeout = rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign rsp_data = rsp_data_q;
  assign EppAstb  = astb_q;
  assign EppDstb  = dstb_q;
  assign EppWR    = wr_q;
  // The host drives the bus only while it holds EppWR low.
  assign EppDB    = wr_q ? 8'hzz : wdata_q;

endmodule
